// File: rtl/and_4_3_dec.sv
// ---------------------------------------------------------------------------
// and_4_3_dec
// Decodes a 5-bit AND-pattern word back into the four source inputs
// (in4..in1) and classifies it: fewer than three inputs high, exactly three,
// all four, or an illegal word. A single registered output stage sits behind
// a valid/ready handshake. Two saturating counters record accepted words and
// accepted illegal words.
//
// Ports
//   clk         : single clock, rising-edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : in_word holds a word offered for transfer
//   in_ready    : block accepts in_word this cycle (combinational)
//   in_word     : {n15, n13, n11, n9, n7}
//   out_valid   : decoded result is held on out_*
//   out_ready   : downstream consumes the result this cycle
//   out_class   : 0 = <3 high, 1 = exactly 3, 2 = all 4, 3 = illegal
//   out_mask    : recovered in4..in1 (bit0 = in1)
//   out_err     : high when out_class = 3
//   clr_counts  : synchronous clear of both counters
//   err_count   : saturating count of accepted illegal words
//   word_count  : saturating count of accepted words
// ---------------------------------------------------------------------------
module and_4_3_dec #(
    parameter int ERR_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [3:0]       out_mask,
    output logic             out_err,
    input  logic             clr_counts,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [1:0] CLASS_NONE  = 2'd0;
    localparam logic [1:0] CLASS_THREE = 2'd1;
    localparam logic [1:0] CLASS_FOUR  = 2'd2;
    localparam logic [1:0] CLASS_ILL   = 2'd3;

    // Returns {class, mask}. Only six words can come from a real set of
    // inputs; anything else is illegal and carries an all-zero mask.
    function automatic logic [5:0] decode_word(input logic [4:0] word);
        logic [5:0] res;
        case (word)
            5'b00000: res = {CLASS_NONE,  4'b0000};
            5'b00010: res = {CLASS_THREE, 4'b0111};
            5'b00100: res = {CLASS_THREE, 4'b1101};
            5'b01000: res = {CLASS_THREE, 4'b1110};
            5'b10000: res = {CLASS_THREE, 4'b1011};
            5'b11111: res = {CLASS_FOUR,  4'b1111};
            default:  res = {CLASS_ILL,   4'b0000};
        endcase
        return res;
    endfunction

    logic             r_out_valid;
    logic [1:0]       r_out_class;
    logic [3:0]       r_out_mask;
    logic             r_out_err;
    logic [ERR_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_word_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_consume;
    logic [5:0]       w_dec;
    logic             w_illegal;

    // Handshake qualifiers and combinational decode of the offered word.
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_consume  = 1'b0;
        w_dec      = 6'd0;
        w_illegal  = 1'b0;
        // The output slot is free when empty or being drained this cycle.
        w_in_ready = (~r_out_valid) | out_ready;
        w_accept   = in_valid & w_in_ready;
        w_consume  = r_out_valid & out_ready;
        w_dec      = decode_word(in_word);
        w_illegal  = (w_dec[5:4] == CLASS_ILL);
    end

    // Output register stage: load on accept, drop valid on a bare consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_class <= 2'd0;
            r_out_mask  <= 4'd0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_class <= w_dec[5:4];
            r_out_mask  <= w_dec[3:0];
            r_out_err   <= w_illegal;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Saturating counters; clear wins over a same-cycle acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= {CNT_W{1'b0}};
            r_err_count  <= {ERR_W{1'b0}};
        end else if (clr_counts) begin
            r_word_count <= {CNT_W{1'b0}};
            r_err_count  <= {ERR_W{1'b0}};
        end else if (w_accept) begin
            if (r_word_count != {CNT_W{1'b1}}) begin
                r_word_count <= r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_word_count <= r_word_count;
            end
            if (w_illegal && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_word_count <= r_word_count;
            r_err_count  <= r_err_count;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_class  = r_out_class;
    assign out_mask   = r_out_mask;
    assign out_err    = r_out_err;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_and_4_3_dec.sv
// ---------------------------------------------------------------------------
// tb_and_4_3_dec
// Self-checking bench for and_4_3_dec. A cycle-level reference model derives
// each expected result by searching all input combinations for one whose AND
// terms reproduce the word, then tracks handshake and counter state.
// ---------------------------------------------------------------------------
module tb_and_4_3_dec;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_class;
    logic [3:0] out_mask;
    logic       out_err;
    logic       clr_counts;
    logic [7:0] err_count;
    logic [15:0] word_count;

    and_4_3_dec #(.ERR_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_mask   (out_mask),
        .out_err    (out_err),
        .clr_counts (clr_counts),
        .err_count  (err_count),
        .word_count (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // reference model state
    logic       m_valid;
    int         m_class;
    int         m_mask;
    int         m_wc;
    int         m_ec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Find a set of inputs whose AND terms give this word. All-zero word is
    // the "fewer than three high" case; otherwise only sets of 3 or 4 high
    // inputs can light any term.
    function automatic void ref_decode(input int word, output int cls, output int msk);
        cls = 3;
        msk = 0;
        if (word == 0) begin
            cls = 0;
        end else begin
            for (int m = 0; m < 16; m++) begin
                int a, b, c, d, pat, pop;
                a = m & 1; b = (m >> 1) & 1; c = (m >> 2) & 1; d = (m >> 3) & 1;
                pat = (a & b & c & d) | ((a & b & c) << 1) | ((a & c & d) << 2)
                    | ((b & c & d) << 3) | ((a & b & d) << 4);
                pop = a + b + c + d;
                if (pop >= 3 && pat == word) begin
                    cls = pop - 2;
                    msk = m;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_class", 32'(out_class), 32'(m_class));
            chk("out_mask", 32'(out_mask), 32'(m_mask));
            chk("out_err", 32'(out_err), 32'(m_class == 3));
        end
        chk("word_count", 32'(word_count), 32'(m_wc));
        chk("err_count", 32'(err_count), 32'(m_ec));
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic iv, input logic [4:0] iw, input logic ordy, input logic clr);
        logic exp_rdy, acc, cons;
        int c, mk;
        in_valid   = iv;
        in_word    = iw;
        out_ready  = ordy;
        clr_counts = clr;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc  = iv && exp_rdy;
        cons = m_valid && ordy;
        @(posedge clk);
        ref_decode(int'(iw), c, mk);
        if (acc) begin
            m_valid = 1'b1;
            m_class = c;
            m_mask  = mk;
        end else if (cons) begin
            m_valid = 1'b0;
        end
        if (clr) begin
            m_wc = 0;
            m_ec = 0;
        end else if (acc) begin
            if (m_wc < 65535) m_wc = m_wc + 1;
            if (c == 3 && m_ec < 255) m_ec = m_ec + 1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_class = 0;
        m_mask  = 0;
        m_wc    = 0;
        m_ec    = 0;
    endtask

    logic [4:0] legal [6];
    logic [4:0] w;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        legal[0] = 5'b00000; legal[1] = 5'b00010; legal[2] = 5'b00100;
        legal[3] = 5'b01000; legal[4] = 5'b10000; legal[5] = 5'b11111;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_word    = 5'd0;
        out_ready  = 1'b0;
        clr_counts = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;

        // full-rate stream
        for (int i = 1; i < 6; i++) cycle(1'b1, legal[i], 1'b1, 1'b0);
        cycle(1'b1, legal[0], 1'b1, 1'b0);
        chk("stream_class0", 32'(out_class), 32'd0);
        chk("stream_wc6", 32'(word_count), 32'd6);
        chk("stream_ec0", 32'(err_count), 32'd0);

        // illegal words
        cycle(1'b1, 5'b00011, 1'b1, 1'b0);
        chk("ill_class", 32'(out_class), 32'd3);
        chk("ill_err", 32'(out_err), 32'd1);
        cycle(1'b1, 5'b01111, 1'b1, 1'b0);
        chk("ill_ec2", 32'(err_count), 32'd2);

        // backpressure: hold 00100 for three cycles, then hand over with no bubble
        cycle(1'b1, 5'b00100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'b01000, 1'b0, 1'b0);
            chk("bp_mask", 32'(out_mask), 32'b1101);
        end
        cycle(1'b1, 5'b01000, 1'b1, 1'b0);
        chk("bp_next_mask", 32'(out_mask), 32'b1110);
        cycle(1'b0, 5'd0, 1'b1, 1'b0);

        // saturation of the illegal-word counter
        for (int i = 0; i < 260; i++) begin
            w = 5'($urandom_range(0, 31));
            if (w == 5'b00000 || w == 5'b00010 || w == 5'b00100 ||
                w == 5'b01000 || w == 5'b10000 || w == 5'b11111) w = 5'b00001;
            cycle(1'b1, w, 1'b1, 1'b0);
        end
        chk("sat_ec255", 32'(err_count), 32'd255);

        // clear coincident with accepting 11111
        cycle(1'b1, 5'b11111, 1'b1, 1'b1);
        chk("clr_wc", 32'(word_count), 32'd0);
        chk("clr_ec", 32'(err_count), 32'd0);
        chk("clr_class", 32'(out_class), 32'd2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) w = legal[$urandom_range(0, 5)];
            else w = 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        // asynchronous reset while a result is held under backpressure
        cycle(1'b1, 5'b11111, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_class", 32'(out_class), 32'd0);
        chk("arst_out_mask", 32'(out_mask), 32'd0);
        chk("arst_out_err", 32'(out_err), 32'd0);
        chk("arst_word_count", 32'(word_count), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 5'b00010, 1'b1, 1'b0);
        chk("post_rst_mask", 32'(out_mask), 32'b0111);
        chk("post_rst_wc", 32'(word_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/and_4_3_dec.md
AND_4_3_DEC -- requirements
Module: and_4_3_dec

Interface
REQ-001 Parameter ERR_W, default 8: width of the saturating illegal-word counter.
REQ-002 Parameter CNT_W, default 16: width of the saturating accepted-word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_word holds a word offered for transfer.
REQ-006 in_ready  output  1  block accepts in_word this cycle.
REQ-007 in_word  input  5  AND-pattern word: bit0=n7 (in1&in2&in3&in4), bit1=n9 (in1&in2&in3), bit2=n11 (in1&in3&in4), bit3=n13 (in2&in3&in4), bit4=n15 (in1&in2&in4).
REQ-008 out_valid  output  1  decoded result is held on the out_* ports.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 out_class  output  2  0 = fewer than three inputs high, 1 = exactly three, 2 = all four, 3 = illegal word.
REQ-011 out_mask  output  4  recovered in4..in1 (bit0 = in1), per REQ-017.
REQ-012 out_err  output  1  high when out_class = 3.
REQ-013 clr_counts  input  1  synchronous clear of both counters.
REQ-014 err_count  output  ERR_W  number of illegal words accepted, saturating.
REQ-015 word_count  output  CNT_W  number of words accepted, saturating.

Function
REQ-016 Transfer rules: a word is accepted when in_valid and in_ready are both high. A result is consumed when out_valid and out_ready are both high.
REQ-017 Decode table. Every other word is illegal and gives class 3 with mask 0000.
- 00000: class 0, mask 0000.
- 00010: class 1, mask 0111.
- 00100: class 1, mask 1101.
- 01000: class 1, mask 1110.
- 10000: class 1, mask 1011.
- 11111: class 2, mask 1111.
REQ-018 Pipeline: a single output register stage; the result of an accepted word appears on out_* with out_valid high exactly one cycle after acceptance.
REQ-019 Backpressure: in_ready = !out_valid || out_ready, combinationally, so the block sustains one word per cycle.
REQ-020 Stability: while out_valid is high and out_ready is low, out_class, out_mask and out_err hold stable.
REQ-021 out_valid clears on the cycle after consumption unless a new word is accepted in that same cycle.
REQ-022 Simultaneous consume and accept: the new result replaces the old one with no bubble.
REQ-023 word_count increments by 1 per accepted word and saturates at all-ones.
REQ-024 err_count increments by 1 per accepted illegal word and saturates at all-ones.
REQ-025 When clr_counts is high, both counters become 0 on the next edge. clr_counts has priority: a word accepted in the same cycle is not counted, but it is still decoded and delivered.
REQ-026 clr_counts has no effect on the data path or on the handshake.
REQ-027 Counter outputs are registered and reflect acceptances up to the previous edge.

Reset
REQ-028 While rst_n is low, outputs take these values immediately, without waiting for a clock edge:
- out_valid = 0, out_class = 0, out_mask = 0, out_err = 0;
- err_count = 0, word_count = 0.
REQ-029 Assertion of rst_n mid-transfer discards any held result; no partial result is presented after release.
REQ-030 After rst_n deasserts, in_ready is high on the first cycle and the first word can be accepted on the first rising edge.

Verification
REQ-031 Bench SHALL cover the following:
- Full-rate stream: in_word 00010, 00100, 01000, 10000, 11111, 00000 with out_ready held high. Required outputs, each one cycle after its word: classes 1,1,1,1,2,0; masks 0111, 1101, 1110, 1011, 1111, 0000; word_count = 6, err_count = 0.
- Illegal words: in_word 00011 -> class 3, out_err = 1, mask 0000. Then 01111 -> class 3. err_count = 2.
- Backpressure: accept 00100, hold out_ready low for 3 cycles. Required: in_ready = 0 and out_mask = 1101 held stable throughout. Next word accepted in the cycle out_ready rises, with no bubble.
- Saturation: 256 illegal words with ERR_W = 8 -> err_count = 255, which then stays 255 on further illegal words.
- clr_counts asserted in the same cycle as accepting 11111. Required: next cycle counters = 0, out_class = 2.
- rst_n pulsed low while out_valid = 1 and out_ready = 0. Required: out_valid = 0 and counters = 0 immediately, without a clock edge; in_ready = 1 after release.
